// File: rtl/fir_l2_pkg.sv
// fir_l2_pkg: shared widths and sample-pair type for the L2 parallel FIR datapath
package fir_l2_pkg;
    localparam int DATA_OUT_WIDTH = 64;
    typedef struct packed {
        logic signed [DATA_OUT_WIDTH-1:0] first;
        logic signed [DATA_OUT_WIDTH-1:0] second;
    } fir_pair_t;
endpackage

// File: rtl/fir_l2_serializer_if.sv
// fir_l2_serializer_if: pair-in / sample-out handshake bundle
//   in_valid/in_ready/in_data_1/in_data_2 : pair side (even, odd sample)
//   out_valid/out_ready/out_data/out_phase : serial side
//   level : pairs stored, including a half-emitted pair
interface fir_l2_serializer_if
    import fir_l2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_OUT_WIDTH,
    parameter int DEPTH      = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data_1;
    logic signed [DATA_WIDTH-1:0] in_data_2;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_phase;
    logic [$clog2(DEPTH):0]       level;
    modport master (
        output in_valid, in_data_1, in_data_2, out_ready,
        input  in_ready, out_valid, out_data, out_phase, level
    );
    modport slave (
        input  in_valid, in_data_1, in_data_2, out_ready,
        output in_ready, out_valid, out_data, out_phase, level
    );
endinterface

// File: rtl/fir_l2_pair_fifo.sv
// fir_l2_pair_fifo: DEPTH-entry circular FIFO of sample pairs
//   clk/reset : clock, synchronous active-high reset (pointers and level only)
//   i_push/i_data : write a pair (ignored when full)
//   i_pop/o_data  : release the head pair (ignored when empty); o_data is the head
//   o_full/o_empty/o_level : occupancy
module fir_l2_pair_fifo
    import fir_l2_pkg::*;
#(
    parameter type T     = fir_pair_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_push;
    logic            w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    // storage is deliberately left out of reset
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    // power-of-two depth: pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
endmodule

// File: rtl/fir_l2_serializer.sv
// fir_l2_serializer: turns buffered (even, odd) sample pairs into one in-order sample stream
//   clk/reset : clock, synchronous active-high reset
//   bus       : slave side of fir_l2_serializer_if (pair input, serial output, level)
module fir_l2_serializer
    import fir_l2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_OUT_WIDTH,
    parameter int DEPTH      = 4
) (
    input logic                clk,
    input logic                reset,
    fir_l2_serializer_if.slave bus
);
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] first;
        logic signed [DATA_WIDTH-1:0] second;
    } pair_t;
    pair_t w_in;
    pair_t w_head;
    logic  w_full;
    logic  w_empty;
    logic  w_push;
    logic  w_pop;
    logic  r_phase;
    assign w_in          = '{first: bus.in_data_1, second: bus.in_data_2};
    // in_ready comes from registered occupancy only, never from out_ready
    assign bus.in_ready  = !reset && !w_full;
    assign bus.out_valid = !reset && !w_empty;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign bus.out_data  = r_phase ? w_head.second : w_head.first;
    assign bus.out_phase = r_phase;
    // the pair leaves the FIFO only once its odd sample is taken
    fir_l2_pair_fifo #(.T(pair_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop && r_phase),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.level)
    );
    always_ff @(posedge clk) begin
        if (reset) r_phase <= 1'b0;
        else if (w_pop) r_phase <= !r_phase;
    end
endmodule

// File: tb/tb_fir_l2_serializer.sv
// tb_fir_l2_serializer: vector table, corner sequences and a queue-model random run
module tb_fir_l2_serializer;
    localparam int DW = 64;
    localparam int DP = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    fir_l2_serializer_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();
    fir_l2_serializer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    typedef struct {
        logic        iv;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        ordy;
        logic        ov;
        logic [63:0] od;
        logic        ph;
        int          lvl;
        logic        ir;
    } vec_t;
    vec_t tbl [6];
    logic [63:0] q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_o(input string nm, input logic ov, input logic [63:0] d,
                            input logic ph, input int lvl, input logic ir);
        chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(ov));
        if (ov) begin
            chk({nm, " out_data"}, bus.out_data, d);
            chk({nm, " out_phase"}, 64'(bus.out_phase), 64'(ph));
        end
        chk({nm, " level"}, 64'(bus.level), 64'(lvl));
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(ir));
    endtask

    task automatic cyc(input logic iv, input logic [63:0] a, input logic [63:0] b, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data_1 = a;
        bus.in_data_2 = b;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("in reset in_ready", 64'(bus.in_ready), 64'(0));
        chk("in reset out_valid", 64'(bus.out_valid), 64'(0));
        reset = 1'b0;
        #1;
        expect_o("after reset", 1'b0, 64'd0, 1'b0, 0, 1'b1);
    endtask

    function automatic logic [63:0] pf(input int k);
        return 64'(-(k * 3 + 1));
    endfunction

    function automatic logic [63:0] ps(input int k);
        return 64'(k * 1000 + 7);
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        bus.out_ready = 1'b0;
        // basic order: (10,11), (-5,7) with out_ready high
        tbl[0] = '{1'b1, 64'd10,  64'd11, 1'b1, 1'b0, 64'd0,   1'b0, 0, 1'b1};
        tbl[1] = '{1'b1, -64'sd5, 64'd7,  1'b1, 1'b1, 64'd10,  1'b0, 1, 1'b1};
        tbl[2] = '{1'b0, 64'd0,   64'd0,  1'b1, 1'b1, 64'd11,  1'b1, 2, 1'b1};
        tbl[3] = '{1'b0, 64'd0,   64'd0,  1'b1, 1'b1, -64'sd5, 1'b0, 1, 1'b1};
        tbl[4] = '{1'b0, 64'd0,   64'd0,  1'b1, 1'b1, 64'd7,   1'b1, 1, 1'b1};
        tbl[5] = '{1'b0, 64'd0,   64'd0,  1'b1, 1'b0, 64'd0,   1'b0, 0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_data_1 = tbl[i].d1;
            bus.in_data_2 = tbl[i].d2;
            bus.out_ready = tbl[i].ordy;
            #1;
            expect_o($sformatf("basic[%0d]", i), tbl[i].ov, tbl[i].od, tbl[i].ph, tbl[i].lvl, tbl[i].ir);
            @(posedge clk);
            #1;
        end

        // fill to full, reject a fifth pair, drain in order
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'(100 + 2 * i), 64'(101 + 2 * i), 1'b0);
        expect_o("full", 1'b1, 64'd100, 1'b0, 4, 1'b0);
        cyc(1'b1, 64'd999, 64'd999, 1'b0);
        expect_o("full reject", 1'b1, 64'd100, 1'b0, 4, 1'b0);
        for (int s = 0; s < 8; s++) begin
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("drain data %0d", s), bus.out_data, 64'(100 + s));
            chk($sformatf("drain phase %0d", s), 64'(bus.out_phase), 64'(s % 2));
            if (s < 2) chk($sformatf("drain in_ready %0d", s), 64'(bus.in_ready), 64'(0));
            else chk($sformatf("drain in_ready %0d", s), 64'(bus.in_ready), 64'(1));
            cyc(1'b0, 64'd0, 64'd0, 1'b1);
        end
        expect_o("drained", 1'b0, 64'd0, 1'b0, 0, 1'b1);

        // backpressure hold
        do_reset();
        cyc(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_o($sformatf("hold %0d", i), 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b1);
            cyc(1'b0, 64'd0, 64'd0, 1'b0);
        end
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("hold odd", 1'b1, 64'd1, 1'b1, 1, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("hold done", 1'b0, 64'd0, 1'b0, 0, 1'b1);

        // simultaneous push and release across the pointer wrap
        do_reset();
        cyc(1'b1, pf(0), ps(0), 1'b0);
        cyc(1'b1, pf(1), ps(1), 1'b0);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        for (int k = 2; k < 8; k++) begin
            expect_o($sformatf("simul odd %0d", k - 2), 1'b1, ps(k - 2), 1'b1, 2, 1'b1);
            cyc(1'b1, pf(k), ps(k), 1'b1);
            expect_o($sformatf("simul even %0d", k - 1), 1'b1, pf(k - 1), 1'b0, 2, 1'b1);
            cyc(1'b0, 64'd0, 64'd0, 1'b1);
        end
        expect_o("simul tail 0", 1'b1, ps(6), 1'b1, 2, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("simul tail 1", 1'b1, pf(7), 1'b0, 1, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("simul tail 2", 1'b1, ps(7), 1'b1, 1, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("simul empty", 1'b0, 64'd0, 1'b0, 0, 1'b1);

        // reset mid-pair discards the odd sample
        do_reset();
        cyc(1'b1, 64'd3, 64'd4, 1'b0);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("mid pair", 1'b1, 64'd4, 1'b1, 1, 1'b1);
        do_reset();
        cyc(1'b1, 64'd8, 64'd9, 1'b1);
        expect_o("post reset even", 1'b1, 64'd8, 1'b0, 1, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);
        expect_o("post reset odd", 1'b1, 64'd9, 1'b1, 1, 1'b1);
        cyc(1'b0, 64'd0, 64'd0, 1'b1);

        // pop attempts while empty
        for (int i = 0; i < 5; i++) begin
            expect_o($sformatf("empty pop %0d", i), 1'b0, 64'd0, 1'b0, 0, 1'b1);
            cyc(1'b0, 64'd0, 64'd0, 1'b1);
        end

        // random traffic against a sample-queue model
        do_reset();
        q = {};
        for (int n = 0; n < 400; n++) begin
            int lv;
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_data_1 = {$urandom, $urandom};
            bus.in_data_2 = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            lv = (q.size() + 1) / 2;
            expect_o("rand", q.size() != 0, (q.size() != 0) ? q[0] : 64'd0,
                     q.size() % 2 == 1, lv, lv != DP);
            if (bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (bus.in_valid && lv != DP) begin
                q.push_back(bus.in_data_1);
                q.push_back(bus.in_data_2);
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
